// File: rtl/tile_layer_mixer.sv
// N-layer tilemap compositor: double-buffered scroll registers committed at
// vblank, plus a two-stage pixel pipeline picking the frontmost opaque layer.
module tile_layer_mixer #(
   parameter  int NUM_LAYERS = 2,
   parameter  int PIX_W      = 4,
   parameter  int COL_W      = 4,
   parameter  int SCROLL_W   = 10,
   localparam int LW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
   input  logic                           CLK_32M,
   input  logic                           RESET_N,
   input  logic                           CE_PIX,
   input  logic                           IOWR,
   input  logic [7:0]                     IO_A,
   input  logic [7:0]                     IO_DIN,
   input  logic                           VBLANK,
   input  logic [NUM_LAYERS-1:0]          LAYER_EN,
   input  logic [NUM_LAYERS*PIX_W-1:0]    LAYER_BIT,
   input  logic [NUM_LAYERS*COL_W-1:0]    LAYER_COL,
   input  logic [NUM_LAYERS-1:0]          LAYER_CP15,
   input  logic [NUM_LAYERS-1:0]          LAYER_CP8,
   output logic [NUM_LAYERS*SCROLL_W-1:0] VSCROLL,
   output logic [NUM_LAYERS*SCROLL_W-1:0] HSCROLL,
   output logic [LW+COL_W+PIX_W-1:0]      PAL_IDX,
   output logic                           PIX_OPAQUE,
   output logic                           P1L
);

   logic                r_vb_prev;
   logic                r_mode;
   logic [SCROLL_W-1:0] r_vsh  [NUM_LAYERS];
   logic [SCROLL_W-1:0] r_hsh  [NUM_LAYERS];
   logic [SCROLL_W-1:0] r_vact [NUM_LAYERS];
   logic [SCROLL_W-1:0] r_hact [NUM_LAYERS];

   logic                w_win;
   logic                w_scr_wr;
   logic                w_mode_wr;
   logic                w_commit;
   logic [15:0]         w_wdata16;
   logic [15:0]         w_mask16;
   logic [SCROLL_W-1:0] w_wdata;
   logic [SCROLL_W-1:0] w_mask;

   assign w_win     = IOWR && (IO_A[7:6] == 2'b10);
   assign w_scr_wr  = w_win && !IO_A[3] &&
                      ({1'b0, IO_A[5:4]} < 3'(NUM_LAYERS));
   assign w_mode_wr = w_win && (IO_A[3:0] == 4'b1000);
   assign w_commit  = VBLANK && !r_vb_prev;

   // Byte lanes as a mask so narrow scroll widths simply drop the high byte
   assign w_wdata16 = {IO_DIN, IO_DIN};
   assign w_mask16  = IO_A[0] ? 16'hFF00 : 16'h00FF;
   assign w_wdata   = w_wdata16[SCROLL_W-1:0];
   assign w_mask    = w_mask16[SCROLL_W-1:0];

   always_ff @(posedge CLK_32M or negedge RESET_N) begin
      if (!RESET_N) begin
         r_vb_prev <= 1'b1;
         r_mode    <= 1'b0;
         for (int i = 0; i < NUM_LAYERS; i++) begin
            r_vsh[i]  <= '0;
            r_hsh[i]  <= '0;
            r_vact[i] <= '0;
            r_hact[i] <= '0;
         end
      end else begin
         r_vb_prev <= VBLANK;
         if (w_mode_wr)
            r_mode <= IO_DIN[0];
         for (int i = 0; i < NUM_LAYERS; i++) begin
            if (w_commit) begin
               r_vact[i] <= r_vsh[i];
               r_hact[i] <= r_hsh[i];
            end
            if (w_scr_wr && (IO_A[5:4] == 2'(i))) begin
               if (IO_A[1])
                  r_hsh[i] <= (r_hsh[i] & ~w_mask) | (w_wdata & w_mask);
               else
                  r_vsh[i] <= (r_vsh[i] & ~w_mask) | (w_wdata & w_mask);
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_scroll
      assign VSCROLL[g*SCROLL_W +: SCROLL_W] = r_vact[g];
      assign HSCROLL[g*SCROLL_W +: SCROLL_W] = r_hact[g];
   end

   logic [NUM_LAYERS-1:0] r_s1_en;
   logic [NUM_LAYERS-1:0] r_s1_cp15;
   logic [NUM_LAYERS-1:0] r_s1_cp8;
   logic [PIX_W-1:0]      r_s1_bit [NUM_LAYERS];
   logic [COL_W-1:0]      r_s1_col [NUM_LAYERS];
   logic                  r_s1_mode;

   always_ff @(posedge CLK_32M or negedge RESET_N) begin
      if (!RESET_N) begin
         r_s1_en   <= '0;
         r_s1_cp15 <= '0;
         r_s1_cp8  <= '0;
         r_s1_mode <= 1'b0;
         for (int i = 0; i < NUM_LAYERS; i++) begin
            r_s1_bit[i] <= '0;
            r_s1_col[i] <= '0;
         end
      end else if (CE_PIX) begin
         r_s1_en   <= LAYER_EN;
         r_s1_cp15 <= LAYER_CP15;
         r_s1_cp8  <= LAYER_CP8;
         r_s1_mode <= r_mode;
         for (int i = 0; i < NUM_LAYERS; i++) begin
            r_s1_bit[i] <= LAYER_BIT[i*PIX_W +: PIX_W];
            r_s1_col[i] <= LAYER_COL[i*COL_W +: COL_W];
         end
      end
   end

   logic [NUM_LAYERS-1:0] w_opq;
   logic [NUM_LAYERS-1:0] w_hit;
   logic [LW-1:0]         w_sel;
   logic [PIX_W-1:0]      w_sel_bit;
   logic [COL_W-1:0]      w_sel_col;

   always_comb begin
      w_opq = '0;
      w_hit = '0;
      for (int k = 0; k < NUM_LAYERS; k++) begin
         w_opq[k] = r_s1_en[k] && (r_s1_bit[k] != '0);
         w_hit[k] = (r_s1_cp15[k] && w_opq[k]) ||
                    (r_s1_cp8[k] && r_s1_en[k] &&
                     r_s1_bit[k][PIX_W-1]);
      end
   end

   // Scan from the back toward the front so the last hit is the winner
   always_comb begin
      w_sel = r_s1_mode ? '0 : LW'(NUM_LAYERS-1);
      if (r_s1_mode) begin
         for (int k = 0; k < NUM_LAYERS; k++)
            if (w_opq[k])
               w_sel = LW'(k);
      end else begin
         for (int k = NUM_LAYERS-1; k >= 0; k--)
            if (w_opq[k])
               w_sel = LW'(k);
      end
   end

   always_comb begin
      w_sel_col = r_s1_col[w_sel];
      w_sel_bit = r_s1_en[w_sel] ? r_s1_bit[w_sel] : '0;
   end

   logic [LW+COL_W+PIX_W-1:0] r_pal_idx;
   logic                      r_opaque;
   logic                      r_p1l;

   always_ff @(posedge CLK_32M or negedge RESET_N) begin
      if (!RESET_N) begin
         r_pal_idx <= '0;
         r_opaque  <= 1'b0;
         r_p1l     <= 1'b1;
      end else if (CE_PIX) begin
         r_pal_idx <= {w_sel, w_sel_col, w_sel_bit};
         r_opaque  <= |w_opq;
         r_p1l     <= ~(|w_hit);
      end
   end

   assign PAL_IDX    = r_pal_idx;
   assign PIX_OPAQUE = r_opaque;
   assign P1L        = r_p1l;

endmodule

// File: tb/tb_tile_layer_mixer.sv
// Directed and random checks of tile_layer_mixer against a behavioural
// model of the scroll double-buffer and the layer priority selection.
module tb_tile_layer_mixer;
   localparam int N  = 2;
   localparam int PW = 4;
   localparam int CW = 4;
   localparam int SW = 10;
   localparam int LW = 1;
   localparam int IW = LW + CW + PW;

   logic            CLK_32M = 1'b0;
   logic            RESET_N = 1'b0;
   logic            CE_PIX = 1'b0;
   logic            IOWR = 1'b0;
   logic [7:0]      IO_A = '0;
   logic [7:0]      IO_DIN = '0;
   logic            VBLANK = 1'b1;
   logic [N-1:0]    LAYER_EN = '0;
   logic [N*PW-1:0] LAYER_BIT = '0;
   logic [N*CW-1:0] LAYER_COL = '0;
   logic [N-1:0]    LAYER_CP15 = '0;
   logic [N-1:0]    LAYER_CP8 = '0;
   logic [N*SW-1:0] VSCROLL;
   logic [N*SW-1:0] HSCROLL;
   logic [IW-1:0]   PAL_IDX;
   logic            PIX_OPAQUE;
   logic            P1L;

   tile_layer_mixer #(
      .NUM_LAYERS(N), .PIX_W(PW), .COL_W(CW), .SCROLL_W(SW)
   ) dut (
      .CLK_32M(CLK_32M), .RESET_N(RESET_N), .CE_PIX(CE_PIX),
      .IOWR(IOWR), .IO_A(IO_A), .IO_DIN(IO_DIN), .VBLANK(VBLANK),
      .LAYER_EN(LAYER_EN), .LAYER_BIT(LAYER_BIT),
      .LAYER_COL(LAYER_COL), .LAYER_CP15(LAYER_CP15),
      .LAYER_CP8(LAYER_CP8), .VSCROLL(VSCROLL), .HSCROLL(HSCROLL),
      .PAL_IDX(PAL_IDX), .PIX_OPAQUE(PIX_OPAQUE), .P1L(P1L)
   );

   always #5 CLK_32M = ~CLK_32M;

   typedef struct packed {
      logic [IW-1:0] idx;
      logic          opq;
      logic          p1l;
   } res_t;

   int   total = 0;
   int   bad = 0;
   int   m_vsh[N], m_hsh[N], m_vact[N], m_hact[N];
   bit   m_mode, m_vbprev;
   res_t m_s1, m_out;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK_32M);
      #1;
   endtask

   // Reference: front layer is the first opaque one in scan order
   function automatic res_t model();
      res_t r;
      int   win, l, b, c, pix;
      bit   any;
      win = -1;
      any = 0;
      for (int i = 0; i < N; i++) begin
         pix = int'(LAYER_BIT[i*PW +: PW]);
         if (LAYER_EN[i] && pix != 0 && (win < 0 || m_mode))
            win = i;
         if (LAYER_CP15[i] && LAYER_EN[i] && pix != 0)
            any = 1;
         if (LAYER_CP8[i] && LAYER_EN[i] && pix >= (1 << (PW-1)))
            any = 1;
      end
      l = (win >= 0) ? win : (m_mode ? 0 : N-1);
      c = int'(LAYER_COL[l*CW +: CW]);
      b = LAYER_EN[l] ? int'(LAYER_BIT[l*PW +: PW]) : 0;
      r.idx = IW'(l * (1 << (CW+PW)) + c * (1 << PW) + b);
      r.opq = (win >= 0);
      r.p1l = !any;
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_vsh[i] = 0; m_hsh[i] = 0; m_vact[i] = 0; m_hact[i] = 0;
      end
      m_mode   = 0;
      m_vbprev = 1;
      m_s1     = '{idx: IW'((N-1) << (CW+PW)), opq: 1'b0, p1l: 1'b1};
      m_out    = '{idx: '0, opq: 1'b0, p1l: 1'b1};
   endtask

   task automatic model_write(logic [7:0] a, logic [7:0] d);
      int l, old, nv;
      if (a[7:6] == 2'b10) begin
         if (!a[3]) begin
            l = int'(a[5:4]);
            if (l < N) begin
               old = a[1] ? m_hsh[l] : m_vsh[l];
               if (a[0]) nv = int'(d) * 256 + old % 256;
               else      nv = (old / 256) * 256 + int'(d);
               nv = nv % (1 << SW);
               if (a[1]) m_hsh[l] = nv;
               else      m_vsh[l] = nv;
            end
         end else if (a[2:0] == 3'b000) begin
            m_mode = d[0];
         end
      end
   endtask

   task automatic chk_scroll();
      for (int i = 0; i < N; i++) begin
         chk("vscroll", 32'(VSCROLL[i*SW +: SW]), 32'(m_vact[i]));
         chk("hscroll", 32'(HSCROLL[i*SW +: SW]), 32'(m_hact[i]));
      end
   endtask

   task automatic cyc(bit wr, logic [7:0] a, logic [7:0] d, bit vb);
      IOWR = wr; IO_A = a; IO_DIN = d; VBLANK = vb;
      tick();
      IOWR = 1'b0;
      if (vb && !m_vbprev)
         for (int i = 0; i < N; i++) begin
            m_vact[i] = m_vsh[i];
            m_hact[i] = m_hsh[i];
         end
      if (wr) model_write(a, d);
      m_vbprev = vb;
      chk_scroll();
   endtask

   task automatic chk_pix(string tag);
      chk({tag, "_idx"}, 32'(PAL_IDX), 32'(m_out.idx));
      chk({tag, "_opq"}, 32'(PIX_OPAQUE), 32'(m_out.opq));
      chk({tag, "_p1l"}, 32'(P1L), 32'(m_out.p1l));
   endtask

   task automatic pulse(string tag);
      res_t cur;
      cur = model();
      CE_PIX = 1'b1;
      tick();
      CE_PIX = 1'b0;
      m_out = m_s1;
      m_s1  = cur;
      chk_pix(tag);
   endtask

   task automatic set_pix(logic [1:0] en, int b0, int c0, int b1, int c1,
                          logic [1:0] cp15, logic [1:0] cp8);
      LAYER_EN   = en;
      LAYER_BIT  = {4'(b1), 4'(b0)};
      LAYER_COL  = {4'(c1), 4'(c0)};
      LAYER_CP15 = cp15;
      LAYER_CP8  = cp8;
   endtask

   task automatic rand_pix();
      LAYER_EN   = N'($urandom);
      LAYER_BIT  = (N*PW)'($urandom);
      LAYER_COL  = (N*CW)'($urandom);
      LAYER_CP15 = N'($urandom);
      LAYER_CP8  = N'($urandom);
      for (int i = 0; i < N; i++)
         if ($urandom % 3 == 0) LAYER_BIT[i*PW +: PW] = '0;
   endtask

   initial begin
      logic [7:0] ra;
      model_reset();

      RESET_N = 1'b0;
      VBLANK  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         rand_pix();
         CE_PIX = 1'b1;
         IOWR = 1'($urandom); IO_A = 8'h82; IO_DIN = 8'($urandom);
         tick();
         chk("rst_idx", 32'(PAL_IDX), 0);
         chk("rst_opq", 32'(PIX_OPAQUE), 0);
         chk("rst_p1l", 32'(P1L), 1);
         chk("rst_vs", 32'(VSCROLL), 0);
         chk("rst_hs", 32'(HSCROLL), 0);
      end
      CE_PIX = 1'b0; IOWR = 1'b0;
      set_pix(2'b00, 0, 0, 0, 0, 2'b00, 2'b00);
      RESET_N = 1'b1;
      tick();
      cyc(0, 8'h00, 8'h00, 1);
      cyc(0, 8'h00, 8'h00, 1);

      cyc(0, 8'h00, 8'h00, 0);
      cyc(1, 8'h82, 8'h34, 0);
      chk("hs_hold0", 32'(HSCROLL[9:0]), 0);
      cyc(1, 8'h83, 8'h01, 0);
      cyc(1, 8'hB2, 8'h55, 0);
      chk("hs_hold1", 32'(HSCROLL[9:0]), 0);
      cyc(0, 8'h00, 8'h00, 1);
      chk("hs_commit", 32'(HSCROLL[9:0]), 32'h134);
      chk("hs_l1", 32'(HSCROLL[19:10]), 0);

      cyc(0, 8'h00, 8'h00, 0);
      cyc(1, 8'h80, 8'h77, 1);
      chk("vs_coll_old", 32'(VSCROLL[9:0]), 0);
      cyc(0, 8'h00, 8'h00, 0);
      cyc(0, 8'h00, 8'h00, 1);
      chk("vs_coll_new", 32'(VSCROLL[9:0]), 32'h077);

      cyc(0, 8'h00, 8'h00, 0);
      cyc(1, 8'h91, 8'hFF, 0);
      cyc(0, 8'h00, 8'h00, 1);
      chk("vs_trunc", 32'(VSCROLL[19:10]), 32'h300);

      set_pix(2'b11, 5, 2, 9, 7, 2'b00, 2'b00);
      pulse("pri"); pulse("pri");
      chk("pri_m0", 32'(PAL_IDX), 32'h025);
      chk("pri_m0_opq", 32'(PIX_OPAQUE), 1);
      cyc(1, 8'h88, 8'h01, 1);
      pulse("pri"); pulse("pri");
      chk("pri_m1", 32'(PAL_IDX), 32'h179);
      cyc(1, 8'h88, 8'h00, 1);
      set_pix(2'b11, 0, 2, 9, 7, 2'b00, 2'b00);
      pulse("pri"); pulse("pri");
      chk("pri_b0z", 32'(PAL_IDX), 32'h179);

      set_pix(2'b11, 0, 2, 0, 7, 2'b00, 2'b00);
      pulse("tr"); pulse("tr");
      chk("tr_idx", 32'(PAL_IDX), 32'h170);
      chk("tr_opq", 32'(PIX_OPAQUE), 0);
      set_pix(2'b10, 5, 2, 0, 7, 2'b00, 2'b00);
      pulse("dis"); pulse("dis");
      chk("dis_idx", 32'(PAL_IDX), 32'h170);
      chk("dis_opq", 32'(PIX_OPAQUE), 0);

      set_pix(2'b11, 3, 1, 0, 4, 2'b01, 2'b00);
      pulse("p1l"); pulse("p1l");
      chk("p1l_cp15", 32'(P1L), 0);
      set_pix(2'b11, 0, 1, 8, 4, 2'b00, 2'b10);
      pulse("p1l"); pulse("p1l");
      chk("p1l_cp8", 32'(P1L), 0);
      set_pix(2'b11, 0, 1, 7, 4, 2'b00, 2'b10);
      pulse("p1l"); pulse("p1l");
      chk("p1l_cp8n", 32'(P1L), 1);

      for (int k = 0; k < 5; k++) begin
         rand_pix();
         tick();
      end
      chk_pix("frozen");

      for (int k = 0; k < 150; k++) begin
         if ($urandom % 8 == 0)
            cyc(1, 8'h88, 8'($urandom), 1);
         rand_pix();
         pulse("rnd_pix");
         if ($urandom % 4 == 0) begin
            rand_pix();
            tick();
            chk_pix("rnd_hold");
         end
      end

      for (int k = 0; k < 200; k++) begin
         ra = ($urandom % 4 != 0) ? (8'h80 | 8'($urandom % 64))
                                  : 8'($urandom);
         cyc(1'($urandom), ra, 8'($urandom),
             ($urandom % 6 == 0) ? !VBLANK : VBLANK);
      end
      cyc(1, 8'h93, 8'h02, 0);
      cyc(1, 8'hA2, 8'h5A, 1);
      rand_pix();
      LAYER_EN = '1;
      LAYER_BIT = 8'h3C;
      LAYER_CP15 = '1;
      pulse("pre_rst"); pulse("pre_rst");
      VBLANK = 1'b1;

      #1 RESET_N = 1'b0;
      #1;
      chk("arst_idx", 32'(PAL_IDX), 0);
      chk("arst_opq", 32'(PIX_OPAQUE), 0);
      chk("arst_p1l", 32'(P1L), 1);
      chk("arst_vs", 32'(VSCROLL), 0);
      chk("arst_hs", 32'(HSCROLL), 0);
      tick();
      RESET_N = 1'b1;
      model_reset();
      cyc(0, 8'h00, 8'h00, 0);
      cyc(0, 8'h00, 8'h00, 1);
      pulse("post_rst");
      chk("post_rst_idx", 32'(PAL_IDX), 32'h100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/tile_layer_mixer.md
# tile_layer_mixer

Parametrised N-layer tilemap compositor for the M72-family video path; successor to the fixed two-layer board-B scheme. It owns per-layer scroll registers, double-buffered from the CPU I/O bus and committed at vertical blank. It takes per-layer pixel/colour/priority outputs from the tile layer engines, selects the frontmost opaque pixel under a programmable priority mode, and emits a registered palette index plus the active-low sprite-priority strobe P1L.

## Interface
Parameters:
- NUM_LAYERS, 2, number of tile layers (1..4); layer 0 is index 0 of every packed bus
- PIX_W, 4, pixel bits per layer; value 0 is transparent
- COL_W, 4, colour/palette-bank bits per layer
- SCROLL_W, 10, scroll register width (2..16)

Ports (LW = $clog2(NUM_LAYERS), minimum 1):
- CLK_32M  in  1  sole clock; all state clocks on its rising edge
- RESET_N  in  1  asynchronous, active-low reset
- CE_PIX  in  1  pixel clock enable; gates the pixel pipeline only
- IOWR  in  1  CPU I/O write strobe, one CLK_32M cycle per access
- IO_A  in  8  I/O address
- IO_DIN  in  8  I/O write data
- VBLANK  in  1  vertical blank level; sampled every CLK_32M
- LAYER_EN  in  NUM_LAYERS  per-layer enable; a disabled layer is treated as transparent
- LAYER_BIT  in  NUM_LAYERS*PIX_W  per-layer pixel value
- LAYER_COL  in  NUM_LAYERS*COL_W  per-layer colour
- LAYER_CP15  in  NUM_LAYERS  per-layer "priority over sprites when opaque"
- LAYER_CP8  in  NUM_LAYERS  per-layer "priority over sprites when pixel MSB set"
- VSCROLL  out  NUM_LAYERS*SCROLL_W  committed vertical scroll per layer
- HSCROLL  out  NUM_LAYERS*SCROLL_W  committed horizontal scroll per layer
- PAL_IDX  out  LW+COL_W+PIX_W  {layer, COL, BIT} of the selected pixel
- PIX_OPAQUE  out  1  selected pixel is non-transparent
- P1L  out  1  active-low: a tile layer wins over sprites at this pixel

## Operation
- Register decode applies only when IOWR=1 and IO_A[7:6]=2'b10.
  - Scroll register, IO_A[3]=0:
    - layer index = IO_A[5:4]; IO_A[1] selects H (1) or V (0); IO_A[0] selects the byte.
    - IO_A[0]=0 writes shadow bits [7:0]; IO_A[0]=1 writes shadow bits [SCROLL_W-1:8].
    - Data bits beyond SCROLL_W are dropped.
  - Mode register, IO_A[3]=1 and IO_A[2:0]=0: writes mode = IO_DIN[0] with immediate effect.
  - Writes to a layer index >= NUM_LAYERS, and any other address in the window, are ignored.
- Commit: on the CLK_32M cycle that detects a VBLANK 0->1 edge (registered previous value), every active scroll register loads its shadow. VSCROLL and HSCROLL present the active copies.
- Opaque test: layer i is opaque iff LAYER_EN[i] and BIT_i != 0.
- Selection:
  - mode 0: the lowest-index opaque layer wins.
  - mode 1: the highest-index opaque layer wins.
  - If no layer is opaque, select the bottom layer: NUM_LAYERS-1 in mode 0, layer 0 in mode 1. Output its {layer, COL, BIT}, with BIT forced to 0 when that layer is disabled, and PIX_OPAQUE=0.
- P1L = NOT OR over i of ((CP15_i & opaque_i) | (CP8_i & LAYER_EN[i] & BIT_i[PIX_W-1])).

## Timing
- Reset values:
  - all shadow and active scroll registers = 0, mode = 0
  - PAL_IDX = 0, PIX_OPAQUE = 0, P1L = 1
  - the VBLANK edge register resets to 1, so a frame already in blank at reset release does not commit.
- Pixel pipeline, 2 stages, each advancing only when CE_PIX=1:
  - S1 registers the LAYER_* inputs and the mode bit.
  - S2 registers PAL_IDX, PIX_OPAQUE and P1L.
  - Latency is 2 CE_PIX pulses; outputs hold when CE_PIX=0.
- Scroll writes land in shadow on the IOWR cycle. VSCROLL/HSCROLL change only on the cycle after the commit edge.
- Simultaneous IOWR and commit in the same cycle: the active register takes the pre-write shadow value, and the new byte commits at the next VBLANK.
- A mode write is seen by S1 on its next CE_PIX pulse.
- Reset asserted mid-frame clears all state asynchronously; no partial commit.

## Test plan
- Reset: hold RESET_N=0 with random inputs -> P1L=1, PAL_IDX=0, PIX_OPAQUE=0, all scrolls 0; release with VBLANK=1 -> no commit.
- Scroll double-buffer: NUM_LAYERS=2, write 0x34 to IO_A=0x82 and 0x01 to IO_A=0x83 (layer 0 H) -> HSCROLL[9:0] stays 0 until VBLANK rises, then reads 0x134 one cycle later. A write to IO_A=0xB2 (layer 3) changes nothing.
- Priority: mode 0, BIT0=5/COL0=2, BIT1=9/COL1=7 -> after 2 CE_PIX, PAL_IDX={0,2,5}. Write mode=1 -> PAL_IDX={1,7,9}. BIT0=0 in mode 0 -> {1,7,9}.
- Transparent and disabled: both BIT=0 -> PIX_OPAQUE=0, PAL_IDX={1,COL1,0}. LAYER_EN=2'b10 with BIT0=5, BIT1=0 -> same result.
- P1L: CP15=2'b01 with BIT0=3 -> P1L=0. CP8=2'b10 with BIT1=8 -> P1L=0. CP8=2'b10 with BIT1=7 -> P1L=1. Hold CE_PIX=0 -> outputs frozen.
- Collision: IOWR to IO_A=0x80 on the same cycle as the VBLANK rise -> VSCROLL[9:0] gets the old shadow, and the new value appears after the following VBLANK rise.
